// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves conditional branches in EX by comparing rs1/rs2 at full XLEN width,
// registers the outcome with one cycle of latency, and keeps a bimodal table of
// 2-bit saturating counters that fetch reads for a taken/not-taken prediction.
// Optional feature macro: BRU_PERF_CNT_EN adds saturating counters of resolved
// branches and mispredicts; without it perf_* are tied to zero.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PERF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_flush,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  output logic              br_valid,
  output logic              br_taken,
  output logic              br_mispredict,
  output logic              br_illegal,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             res;
  logic             cond;
  logic             illegal;
  logic             mispred;
  logic             unused_pc_bits;

  // Word-aligned PCs: bits [1:0] never select an entry, upper bits alias.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  assign res     = ex_valid & ex_branch & ~ex_flush;
  assign mispred = (cond != ex_pred_taken);

  // Prediction is read straight from the table; an update landing on the same
  // edge is not forwarded.
  assign if_pred_taken = bht[if_idx][1];

  // Branch condition decode; the two reserved encodings resolve as not-taken.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 <  ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: illegal = 1'b1;
    endcase
  end

  // Registered resolution outcome, cleared whenever nothing resolves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_valid      <= 1'b0;
      br_taken      <= 1'b0;
      br_mispredict <= 1'b0;
      br_illegal    <= 1'b0;
    end else begin
      br_valid      <= res;
      br_taken      <= res & cond;
      br_mispredict <= res & mispred;
      br_illegal    <= res & illegal;
    end
  end

  // Train the resolved entry toward the actual outcome, saturating at 00/11.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (res) begin
      if (cond && (bht[ex_idx] != 2'b11)) begin
        bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else if (!cond && (bht[ex_idx] != 2'b00)) begin
        bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [PERF_W-1:0] branches_cnt;
  logic [PERF_W-1:0] mispred_cnt;

  // Saturating event counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      branches_cnt <= '0;
      mispred_cnt  <= '0;
    end else if (res) begin
      if (~&branches_cnt) begin
        branches_cnt <= branches_cnt + 1'b1;
      end
      if (mispred && (~&mispred_cnt)) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end

  assign perf_branches = branches_cnt;
  assign perf_mispred  = mispred_cnt;
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver issues one EX slot per
// cycle, a reference model predicts the registered outcome and pushes it into a
// queue, and a negedge monitor pops and compares whenever br_valid is seen.
module tb_branch_resolve_unit;

  localparam int XL = 32;
  localparam int DEPTH = 16;
  localparam int PW = 4;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct packed {
    bit taken;
    bit mispredict;
    bit illegal;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [XL-1:0] if_pc;
  logic          if_pred_taken;
  logic          ex_valid, ex_branch, ex_flush;
  logic [2:0]    ex_funct3;
  logic [XL-1:0] ex_rs1, ex_rs2, ex_pc;
  logic          ex_pred_taken;
  logic          br_valid, br_taken, br_mispredict, br_illegal;
  logic [PW-1:0] perf_branches, perf_mispred;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  int   model_ctr[DEPTH];
  int   model_pb = 0;
  int   model_pm = 0;

  branch_resolve_unit #(.XLEN(XL), .BHT_DEPTH(DEPTH), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_flush(ex_flush),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .br_valid(br_valid), .br_taken(br_taken),
    .br_mispredict(br_mispredict), .br_illegal(br_illegal),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [2:0] f3, input logic [XL-1:0] a, input logic [XL-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return {1'b0, a} < {1'b0, b};
      3'd7: return {1'b0, a} >= {1'b0, b};
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [XL-1:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  // One EX slot: drive, check prediction/perf against the model, then advance
  // the model to what the upcoming edge must produce.
  task automatic issue(input bit r, input bit v, input bit b, input bit f,
                       input logic [2:0] f3, input logic [XL-1:0] a,
                       input logic [XL-1:0] bb, input logic [XL-1:0] pc,
                       input bit p, input logic [XL-1:0] ipc);
    bit c, ill, rs;
    int k;
    rst = r; ex_valid = v; ex_branch = b; ex_flush = f; ex_funct3 = f3;
    ex_rs1 = a; ex_rs2 = bb; ex_pc = pc; ex_pred_taken = p; if_pc = ipc;
    #1;
    if (mon_en) begin
      chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, model_ctr[idx_of(ipc)] >= 2});
`ifdef BRU_PERF_CNT_EN
      chk("perf_branches", {28'd0, perf_branches}, model_pb);
      chk("perf_mispred", {28'd0, perf_mispred}, model_pm);
`else
      chk("perf_branches_tied", {28'd0, perf_branches}, 0);
      chk("perf_mispred_tied", {28'd0, perf_mispred}, 0);
`endif
    end
    rs  = v && b && !f;
    c   = ref_cond(f3, a, bb);
    ill = (f3 == 3'd2) || (f3 == 3'd3);
    if (!r) begin
      foreach (model_ctr[i]) model_ctr[i] = 1;
      model_pb = 0;
      model_pm = 0;
    end else if (rs) begin
      exp_q.push_back('{taken: c, mispredict: (c != p), illegal: ill});
      k = idx_of(pc);
      model_ctr[k] = c ? ((model_ctr[k] < 3) ? model_ctr[k] + 1 : 3)
                       : ((model_ctr[k] > 0) ? model_ctr[k] - 1 : 0);
      if (model_pb < PMAX) model_pb++;
      if ((c != p) && (model_pm < PMAX)) model_pm++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [XL-1:0] ipc);
    issue(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, ipc);
  endtask

  // Monitor: pops one expectation per presented result; quiet cycles must be all-zero.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (br_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid: got br_valid=1 expected no result at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("br_taken", {31'd0, br_taken}, {31'd0, e.taken});
          chk("br_mispredict", {31'd0, br_mispredict}, {31'd0, e.mispredict});
          chk("br_illegal", {31'd0, br_illegal}, {31'd0, e.illegal});
        end
      end else begin
        chk("idle_outputs", {29'd0, br_valid, br_taken, br_mispredict, br_illegal}, 0);
      end
    end
  end

  initial begin
    foreach (model_ctr[i]) model_ctr[i] = 1;
    issue(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // Reset state and training at 0x40 (entry 0).
    idle(32'h40);
    chk("pred_0x40_reset", {31'd0, if_pred_taken}, 0);
    issue(1, 1, 1, 0, 3'd0, 32'h5, 32'h5, 32'h40, 0, 32'h40);
    issue(1, 1, 1, 0, 3'd0, 32'h5, 32'h5, 32'h40, 0, 32'h40);
    chk("pred_0x40_trained", {31'd0, if_pred_taken}, 1);

    // Signed vs unsigned compare of the same operands.
    issue(1, 1, 1, 0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h104, 0, 32'h104);
    issue(1, 1, 1, 0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h108, 0, 32'h108);

    // 0x80 aliases entry 0 (now 11): walk down and saturate at 00.
    issue(1, 1, 1, 0, 3'd1, 32'h7, 32'h7, 32'h80, 1, 32'h80);
    chk("pred_0x80_weak_t", {31'd0, if_pred_taken}, 1);
    issue(1, 1, 1, 0, 3'd1, 32'h7, 32'h7, 32'h80, 1, 32'h80);
    chk("pred_0x80_weak_nt", {31'd0, if_pred_taken}, 0);
    issue(1, 1, 1, 0, 3'd1, 32'h7, 32'h7, 32'h80, 0, 32'h80);
    issue(1, 1, 1, 0, 3'd1, 32'h7, 32'h7, 32'h80, 0, 32'h80);
    issue(1, 1, 1, 0, 3'd0, 32'h7, 32'h7, 32'h80, 0, 32'h80);
    chk("pred_0x80_sat_low", {31'd0, if_pred_taken}, 0);

    // Illegal encoding, then flushed branches that must not train.
    issue(1, 1, 1, 0, 3'd2, 32'h3, 32'h3, 32'h20C, 1, 32'h20C);
    issue(1, 1, 1, 1, 3'd0, 32'h3, 32'h3, 32'h20C, 0, 32'h20C);
    issue(1, 1, 1, 1, 3'd0, 32'h3, 32'h3, 32'h20C, 0, 32'h20C);
    issue(1, 1, 1, 1, 3'd0, 32'h3, 32'h3, 32'h20C, 0, 32'h20C);
    chk("pred_flush_no_train", {31'd0, if_pred_taken}, 0);

    // Same-cycle lookup/update at index 5, then the aliasing PC 0x54.
    issue(1, 1, 1, 0, 3'd0, 32'h9, 32'h9, 32'h14, 0, 32'h14);
    chk("pred_idx5_after", {31'd0, if_pred_taken}, 1);
    idle(32'h54);
    chk("pred_alias_0x54", {31'd0, if_pred_taken}, 1);

    // Reset with a resolution in flight.
    issue(1, 1, 1, 0, 3'd0, 32'h1, 32'h1, 32'h14, 0, 32'h14);
    issue(0, 1, 1, 0, 3'd0, 32'h1, 32'h1, 32'h14, 1, 32'h14);
    idle(32'h14);
    chk("pred_after_reset", {31'd0, if_pred_taken}, 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [XL-1:0] a, bb, pc, ipc;
      a   = $urandom;
      bb  = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? XL'($urandom_range(0, 7)) : $urandom);
      pc  = XL'($urandom_range(0, 255));
      ipc = ($urandom_range(0, 3) == 0) ? pc : XL'($urandom_range(0, 255));
      issue(($urandom_range(0, 79) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 7) == 0),
            3'($urandom_range(0, 7)), a, bb, pc, 1'($urandom_range(0, 1)), ipc);
    end

    idle(0);
    idle(0);
    idle(0);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
